// File: rtl/audio_pkg.sv
// Shared sample width and FSM encodings
// for the mic-to-FFT frame sequencer.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_WAIT = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_PREF   = 2'd1,
    R_STREAM = 2'd2
  } r_state_e;

endpackage

// File: rtl/audio_frame_ctrl_ram.sv
// Simple dual-port frame RAM: one write
// port, one registered read port (BRAM).
module frame_bank_ram #(
  parameter int AW = 11,
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/audio_frame_ctrl.sv
// Ping-pong framer: mic samples in, frames
// out over valid/ready/last, with counters.
module audio_frame_ctrl
  import audio_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                mic_valid_i,
  input  logic [SAMPLE_W-1:0] mic_data_i,
  output logic [SAMPLE_W-1:0] m_tdata_o,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic [CNT_W-1:0]    frame_count_o,
  output logic [CNT_W-1:0]    drop_count_o,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE =
    ADDR_W'(1);

  w_state_e w_state, w_state_n;
  logic w_bank, w_bank_n;
  logic [ADDR_W-1:0] w_idx, w_idx_n;
  logic we, set_full, drop;
  logic [1:0] full, set_vec, clr_vec;

  r_state_e r_state, r_state_n;
  logic r_bank, r_bank_n;
  logic [ADDR_W-1:0] r_idx, r_idx_n;
  logic r_done, r_done_n;
  logic re, clr_full;
  logic pend, pend_last;
  logic [SAMPLE_W-1:0] rdata;

  logic [SAMPLE_W-1:0] q0_d, q1_d;
  logic q0_l, q1_l;
  logic [1:0] cnt;
  logic [2:0] occ;
  logic pop, last_xfer;

  frame_bank_ram #(
    .AW(ADDR_W + 1),
    .DW(SAMPLE_W)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (we),
    .waddr_i({w_bank, w_idx}),
    .wdata_i(mic_data_i),
    .re_i   (re),
    .raddr_i({r_bank, r_idx}),
    .rdata_o(rdata)
  );

  // In W_WAIT/W_IDLE w_bank is the bank
  // last written; the other is awaited.
  always_comb begin
    w_state_n = w_state;
    w_bank_n  = w_bank;
    w_idx_n   = w_idx;
    we        = 1'b0;
    set_full  = 1'b0;
    drop      = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (enable_i) begin
          w_idx_n = '0;
          if (!full[w_bank]) begin
            w_state_n = W_FILL;
          end else if (!full[~w_bank]) begin
            w_state_n = W_FILL;
            w_bank_n  = ~w_bank;
          end else begin
            w_state_n = W_WAIT;
          end
        end
      end
      W_FILL: begin
        if (!enable_i) begin
          w_state_n = W_IDLE;
          w_idx_n   = '0;
        end else if (mic_valid_i) begin
          we = 1'b1;
          if (w_idx == LAST) begin
            set_full = 1'b1;
            w_idx_n  = '0;
            if (!full[~w_bank]) begin
              w_bank_n = ~w_bank;
            end else begin
              w_state_n = W_WAIT;
            end
          end else begin
            w_idx_n = w_idx + ONE;
          end
        end
      end
      W_WAIT: begin
        if (!enable_i) begin
          w_state_n = W_IDLE;
        end else begin
          drop = mic_valid_i;
          if (!full[~w_bank]) begin
            w_state_n = W_FILL;
            w_bank_n  = ~w_bank;
            w_idx_n   = '0;
          end
        end
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  assign pop       = m_tvalid_o & m_tready_i;
  assign last_xfer = pop & q0_l;
  assign occ = {1'b0, cnt} + {2'b0, pend};

  // Reads are issued only while the skid
  // buffer plus the in-flight read fit.
  always_comb begin
    r_state_n = r_state;
    r_bank_n  = r_bank;
    r_idx_n   = r_idx;
    r_done_n  = r_done;
    re        = 1'b0;
    clr_full  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (full[r_bank]) begin
          re        = 1'b1;
          r_idx_n   = r_idx + ONE;
          r_done_n  = 1'b0;
          r_state_n = R_PREF;
        end
      end
      R_PREF, R_STREAM: begin
        r_state_n = R_STREAM;
        if (!r_done &&
            occ < 3'd2 + {2'b0, pop}) begin
          re      = 1'b1;
          r_idx_n = r_idx + ONE;
          if (r_idx == LAST) r_done_n = 1'b1;
        end
        if (last_xfer) begin
          clr_full  = 1'b1;
          r_bank_n  = ~r_bank;
          r_state_n = R_IDLE;
        end
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    set_vec[w_bank] = set_full;
    clr_vec[r_bank] = clr_full;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      w_bank  <= 1'b0;
      w_idx   <= '0;
      r_state <= R_IDLE;
      r_bank  <= 1'b0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      full    <= '0;
      pend    <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      w_state <= w_state_n;
      w_bank  <= w_bank_n;
      w_idx   <= w_idx_n;
      r_state <= r_state_n;
      r_bank  <= r_bank_n;
      r_idx   <= r_idx_n;
      r_done  <= r_done_n;
      full    <= (full | set_vec) & ~clr_vec;
      pend    <= re;
      pend_last <= re && (r_idx == LAST);
    end
  end

  // Two-entry skid buffer; q0 is the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q0_d <= '0;
      q1_d <= '0;
      q0_l <= 1'b0;
      q1_l <= 1'b0;
      cnt  <= '0;
    end else if (pend && !pop) begin
      if (cnt == 2'd0) begin
        q0_d <= rdata;
        q0_l <= pend_last;
      end else begin
        q1_d <= rdata;
        q1_l <= pend_last;
      end
      cnt <= cnt + 2'd1;
    end else if (!pend && pop) begin
      q0_d <= q1_d;
      q0_l <= q1_l;
      cnt  <= cnt - 2'd1;
    end else if (pend && pop) begin
      if (cnt == 2'd1) begin
        q0_d <= rdata;
        q0_l <= pend_last;
      end else begin
        q0_d <= q1_d;
        q0_l <= q1_l;
        q1_d <= rdata;
        q1_l <= pend_last;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_count_o <= '0;
      drop_count_o  <= '0;
      overrun_o     <= 1'b0;
    end else begin
      overrun_o <= drop;
      if (last_xfer)
        frame_count_o <= frame_count_o + CNT_W'(1);
      if (drop && drop_count_o != '1)
        drop_count_o <= drop_count_o + CNT_W'(1);
    end
  end

  assign m_tvalid_o = (cnt != 2'd0);
  assign m_tdata_o  = q0_d;
  assign m_tlast_o  = q0_l & m_tvalid_o;
  assign busy_o = (|full) | (r_state != R_IDLE);

endmodule

// File: doc/audio_frame_ctrl.md
Name: audio_frame_ctrl

Overview:
- Sequences the 48 kHz mic sample stream (data_mic / data_mic_valid) into fixed-length frames for the FFT.
- Writes samples into a two-bank ping-pong buffer. Streams each completed bank to the FFT over a valid/ready/last handshake.
- Reports frame and overrun counts to the MicroBlaze register interface.
- Sits between the microphone decode path and the FFT core, all on the 100 MHz clk_i domain.

Parameters:
- FRAME_LEN, 1024, samples per frame; must be a power of two, at least 4.
- ADDR_W, 10, log2(FRAME_LEN).
- CNT_W, 16, width of frame_count_o and drop_count_o.

Ports:
- clk_i  in  1  100 MHz system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  capture enable (level).
- mic_valid_i  in  1  one-cycle sample strobe, 48 kHz.
- mic_data_i  in  16  signed time sample.
- m_tdata_o  out  16  frame sample to FFT.
- m_tvalid_o  out  1  m_tdata_o valid.
- m_tready_i  in  1  FFT accepts sample.
- m_tlast_o  out  1  marks sample FRAME_LEN-1 of a frame.
- frame_count_o  out  CNT_W  frames fully streamed; wraps.
- drop_count_o  out  CNT_W  samples dropped; saturates at all-ones.
- overrun_o  out  1  one-cycle pulse per dropped sample.
- busy_o  out  1  high when any bank is full or streaming.

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0; both banks empty; write index 0; write bank 0; read bank 0.
- Write FSM states: W_IDLE, W_FILL, W_WAIT.
  - W_IDLE: enable_i=0; samples ignored without counting. enable_i=1 → W_FILL on target bank, index 0.
  - W_FILL: each mic_valid_i writes mic_data_i at the current index, then index++.
  - The write at index FRAME_LEN-1 sets the bank's full flag on the same edge.
  - After that write: if the other bank is empty, write bank toggles and index goes to 0 (stay W_FILL); otherwise → W_WAIT.
  - W_WAIT: every mic_valid_i is dropped. Each drop pulses overrun_o and increments drop_count_o.
  - W_WAIT leaves when the other bank's full flag is observed clear (registered): toggle bank, index 0, → W_FILL.
  - A bank freed on the same edge a sample arrives in W_WAIT does not prevent that sample's drop.
  - enable_i falling in W_FILL: partial frame discarded, index 0, → W_IDLE. Full banks are still streamed out.
  - enable_i falling in W_WAIT: → W_IDLE, no further drops counted.
- Read FSM states: R_IDLE, R_PREF, R_STREAM.
  - R_IDLE: when the read bank is full → R_PREF, issuing RAM read of address 0.
  - RAM read latency is 1 cycle. First m_tvalid_o rises on the 2nd edge after the edge that set the full flag.
  - R_STREAM: a 2-entry output skid buffer gives full throughput. With m_tready_i held high, one sample transfers per cycle.
  - m_tdata_o, m_tvalid_o and m_tlast_o hold stable while m_tvalid_o=1 and m_tready_i=0.
  - Transfer of the sample with m_tlast_o=1: clear that bank's full flag, increment frame_count_o, toggle read bank → R_IDLE.
  - If the next bank is already full, R_IDLE → R_PREF immediately (one bubble cycle between frames is allowed, not required).
- Samples leave in write order. Bank order alternates strictly 0,1,0,1.
- Full flag set and clear on the same bank in one cycle cannot occur. Set by the write side and clear by the read side on different banks in the same cycle are both honoured.
- busy_o = OR of the full flags, OR read FSM not in R_IDLE.

Decomposition:
- Shared package audio_pkg holds:
  - SAMPLE_W=16;
  - write-state encoding (W_IDLE=0, W_FILL=1, W_WAIT=2);
  - read-state encoding (R_IDLE=0, R_PREF=1, R_STREAM=2).
- One sub-module, frame_bank_ram: simple dual-port RAM, depth 2*FRAME_LEN × 16, one write port and one registered read port.
  - Address = {bank, index}. Infers BRAM.
- Skid buffer stays inline in audio_frame_ctrl.

Test Plan (FRAME_LEN=8, ADDR_W=3):
- Reset release, enable=1, 8 strobes with data 1..8, m_tready_i=1 → m_tvalid_o rises 2 edges after the 8th write; outputs 1..8 on consecutive cycles; m_tlast_o only with 8; frame_count_o=1.
- Backpressure: m_tready_i toggles 1,0,0,1,… during frame → every sample 1..8 delivered once, in order; data held stable while stalled.
- Overrun: m_tready_i=0, feed 20 strobes → banks hold 1..8 and 9..16; samples 17..20 dropped; drop_count_o=4; four overrun_o pulses. Releasing tready streams 1..8 then 9..16.
- enable_i dropped after 5 samples of a new frame → no frame emitted. Re-enable and feed 8 → frame contains only the new 8 values.
- rst_ni asserted mid-stream (m_tvalid_o=1) → all outputs 0 asynchronously. After release, the next full 8-sample frame streams normally; frame_count_o restarts at 1.
- Drop saturation: CNT_W=4, force 20 drops → drop_count_o stays at 15.
